// File: rtl/ariane_host_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ariane_host_pkg
//  Description : Shared constants, state encoding and report helper for the
//                multi-hart simulation host monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
package ariane_host_pkg;

    // Environment-call exception causes (U, S and M mode)
    localparam logic [63:0] c_CAUSE_ECALL_U = 64'h8;
    localparam logic [63:0] c_CAUSE_ECALL_S = 64'h9;
    localparam logic [63:0] c_CAUSE_ECALL_M = 64'hB;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } host_state_e;

    // True for any of the three environment-call causes
    function automatic logic is_ecall_cause(input logic [63:0] cause);
        return (cause == c_CAUSE_ECALL_U) || (cause == c_CAUSE_ECALL_S) ||
               (cause == c_CAUSE_ECALL_M);
    endfunction

    // Milli-IPC; a zero cycle count reports as zero instead of dividing
    function automatic logic [63:0] calc_mipc(input logic [63:0] instret,
                                              input logic [63:0] cycle);
        logic [63:0] scaled;
        scaled = instret * 64'd1000;
        return (cycle == 64'd0) ? 64'd0 : (scaled / cycle);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ariane_host_hart_slot.sv
`default_nettype none
// ============================================================================
//  Module      : ariane_host_hart_slot
//  Description : Per-hart ecall detector and one-shot capture of the cycle,
//                instret and exit code observed at the hart's first ecall.
//  Revision    : 1.0 - initial release
// ============================================================================
module ariane_host_hart_slot
    import ariane_host_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        capture_en_i,
    input  logic        ex_i,
    input  logic [63:0] cause_i,
    input  logic [63:0] exit_code_i,
    input  logic [63:0] cycle_i,
    input  logic [63:0] instret_i,
    output logic        capture_o,
    output logic        done_o,
    output logic [63:0] fin_cycle_o,
    output logic [63:0] fin_instret_o,
    output logic [63:0] exit_code_o
);

    logic        done_q,    done_d;
    logic [63:0] cycle_q,   cycle_d;
    logic [63:0] instret_q, instret_d;
    logic [63:0] code_q,    code_d;

    // Only the first ecall seen while the host is running is recorded
    assign capture_o = capture_en_i && ex_i && is_ecall_cause(cause_i) && !done_q;

    // Next-state: load all three captures together on the first ecall
    always_comb begin
        done_d    = done_q;
        cycle_d   = cycle_q;
        instret_d = instret_q;
        code_d    = code_q;
        if (capture_o) begin
            done_d    = 1'b1;
            cycle_d   = cycle_i;
            instret_d = instret_i;
            code_d    = exit_code_i;
        end
    end

    // Capture registers with asynchronous clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q    <= 1'b0;
            cycle_q   <= 64'd0;
            instret_q <= 64'd0;
            code_q    <= 64'd0;
        end else begin
            done_q    <= done_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            code_q    <= code_d;
        end
    end

    assign done_o        = done_q;
    assign fin_cycle_o   = cycle_q;
    assign fin_instret_o = instret_q;
    assign exit_code_o   = code_q;

endmodule
`default_nettype wire

// File: rtl/ariane_multihart_host.sv
`default_nettype none
// ============================================================================
//  Module      : ariane_multihart_host
//  Description : Simulation host that watches every hart for its first ecall,
//                drains for a few clocks once all harts finished, guards the
//                run with a watchdog and prints a per-hart report at the end.
//  Revision    : 1.0 - initial release
// ============================================================================
module ariane_multihart_host
    import ariane_host_pkg::*;
#(
    parameter int unsigned NR_HARTS       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned DRAIN_CYCLES   = 16,
    parameter int unsigned FINISH_EN      = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NR_HARTS-1:0]            ex_i,
    input  logic [NR_HARTS-1:0][63:0]      cause_i,
    input  logic [NR_HARTS-1:0][63:0]      exit_code_i,
    input  logic [NR_HARTS-1:0][63:0]      cycle_i,
    input  logic [NR_HARTS-1:0][63:0]      instret_i,
    output logic [NR_HARTS-1:0]            hart_done_o,
    output logic [NR_HARTS-1:0][63:0]      fin_cycle_o,
    output logic [NR_HARTS-1:0][63:0]      fin_instret_o,
    output logic                           all_done_o,
    output logic                           timeout_o,
    output logic                           fail_o,
    output logic [1:0]                     state_o
);

    localparam logic        c_WD_EN      = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] c_WD_LAST    = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] c_DRAIN_LAST = (DRAIN_CYCLES == 0)   ? 32'd0 : 32'(DRAIN_CYCLES - 1);

    host_state_e                  state_q, state_d;
    logic [31:0]                  wd_q,    wd_d;
    logic [31:0]                  drain_q, drain_d;
    logic [NR_HARTS-1:0]          capture;
    logic [NR_HARTS-1:0]          code_nz;
    logic [NR_HARTS-1:0][63:0]    exit_code;
    logic                         capture_en;

    assign capture_en = (state_q == ST_RUN);

    generate
        for (genvar h = 0; h < int'(NR_HARTS); h++) begin : g_hart
            ariane_host_hart_slot u_slot (
                .clk_i         (clk_i),
                .rst_ni        (rst_ni),
                .capture_en_i  (capture_en),
                .ex_i          (ex_i[h]),
                .cause_i       (cause_i[h]),
                .exit_code_i   (exit_code_i[h]),
                .cycle_i       (cycle_i[h]),
                .instret_i     (instret_i[h]),
                .capture_o     (capture[h]),
                .done_o        (hart_done_o[h]),
                .fin_cycle_o   (fin_cycle_o[h]),
                .fin_instret_o (fin_instret_o[h]),
                .exit_code_o   (exit_code[h])
            );
            assign code_nz[h] = hart_done_o[h] && (exit_code[h] != 64'd0);
        end
    endgenerate

    // Next-state: drain once all harts are done; the watchdog is held off when
    // the final ecall lands on its expiry clock so completion takes priority
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        drain_d = drain_q;
        unique case (state_q)
            ST_RUN: begin
                wd_d = wd_q + 32'd1;
                if (&hart_done_o) begin
                    state_d = ST_DRAIN;
                    drain_d = 32'd0;
                end else if (c_WD_EN && (wd_q == c_WD_LAST) && !(&(hart_done_o | capture))) begin
                    state_d = ST_TIMEOUT;
                end
            end
            ST_DRAIN: begin
                if (drain_q == c_DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + 32'd1;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RUN;
            wd_q    <= 32'd0;
            drain_q <= 32'd0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            drain_q <= drain_d;
        end
    end

    assign all_done_o = (state_q == ST_DONE);
    assign timeout_o  = (state_q == ST_TIMEOUT);
    assign fail_o     = |code_nz;
    assign state_o    = state_q;

`ifndef SYNTHESIS
    logic reported_q;

    // One-shot end-of-run report once a terminal state is reached
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reported_q <= 1'b0;
        end else if (!reported_q && (state_q == ST_DONE || state_q == ST_TIMEOUT)) begin
            reported_q <= 1'b1;
            for (int h = 0; h < int'(NR_HARTS); h++) begin
                $display("[host] hart %0d done=%0d cycle=%0d instret=%0d exit=%0d mIPC=%0d",
                         h, hart_done_o[h], fin_cycle_o[h], fin_instret_o[h], exit_code[h],
                         calc_mipc(fin_instret_o[h], fin_cycle_o[h]));
            end
            if (state_q == ST_TIMEOUT) begin
                $display("[host] TIMEOUT");
            end else if (fail_o) begin
                $display("[host] FAIL");
            end else begin
                $display("[host] PASS");
            end
            if (FINISH_EN != 0) begin
                $finish;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ariane_multihart_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ariane_multihart_host
//  Description : Self-checking bench with a behavioural host model, directed
//                scenarios and randomized ecall traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ariane_multihart_host;

    localparam int unsigned NH = 2;
    localparam int unsigned TO = 50;
    localparam int unsigned DR = 16;

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b0;
    logic [NH-1:0]         ex = '0;
    logic [NH-1:0][63:0]   cause = '0;
    logic [NH-1:0][63:0]   code = '0;
    logic [NH-1:0][63:0]   cyc = '0;
    logic [NH-1:0][63:0]   ins = '0;
    logic [NH-1:0]         hart_done;
    logic [NH-1:0][63:0]   fin_cyc;
    logic [NH-1:0][63:0]   fin_ins;
    logic                  all_done, timeout, fail;
    logic [1:0]            state;

    ariane_multihart_host #(
        .NR_HARTS(NH), .TIMEOUT_CYCLES(TO), .DRAIN_CYCLES(DR), .FINISH_EN(0)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .ex_i(ex), .cause_i(cause),
        .exit_code_i(code), .cycle_i(cyc), .instret_i(ins),
        .hart_done_o(hart_done), .fin_cycle_o(fin_cyc), .fin_instret_o(fin_ins),
        .all_done_o(all_done), .timeout_o(timeout), .fail_o(fail), .state_o(state)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int n_edge  = 0;

    // Behavioural model: phase 0 run, 1 drain, 2 done, 3 timeout
    int          m_phase;
    int unsigned m_run_clks;
    int unsigned m_drain_clks;
    bit          m_done [NH];
    logic [63:0] m_cyc  [NH];
    logic [63:0] m_ins  [NH];
    logic [63:0] m_code [NH];

    function automatic bit m_fail();
        bit f = 0;
        for (int h = 0; h < int'(NH); h++) f |= m_done[h] && (m_code[h] != 0);
        return f;
    endfunction

    function automatic bit m_all_done();
        bit a = 1;
        for (int h = 0; h < int'(NH); h++) a &= m_done[h];
        return a;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_run_clks = 0; m_drain_clks = 0;
        for (int h = 0; h < int'(NH); h++) begin
            m_done[h] = 0; m_cyc[h] = 0; m_ins[h] = 0; m_code[h] = 0;
        end
    endtask

    // One clock of the host rules applied to the inputs present at the edge
    task automatic model_clock();
        bit was_all;
        if (m_phase == 0) begin
            was_all = m_all_done();
            for (int h = 0; h < int'(NH); h++) begin
                if (!m_done[h] && ex[h] && (cause[h] == 64'h8 || cause[h] == 64'h9 || cause[h] == 64'hB)) begin
                    m_done[h] = 1; m_cyc[h] = cyc[h]; m_ins[h] = ins[h]; m_code[h] = code[h];
                end
            end
            // The watchdog expires on the TO-th RUN clock unless every hart is finished by then
            if (was_all) begin
                m_phase = 1; m_drain_clks = 0;
            end else if (TO != 0 && m_run_clks + 1 == TO && !m_all_done()) begin
                m_phase = 3;
            end
            m_run_clks++;
        end else if (m_phase == 1) begin
            m_drain_clks++;
            if (m_drain_clks == ((DR == 0) ? 1 : DR)) m_phase = 2;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, n_edge, act, exp);
        end
    endtask

    task automatic compare();
        for (int h = 0; h < int'(NH); h++) begin
            check($sformatf("hart_done[%0d]", h), 64'(hart_done[h]), 64'(m_done[h]));
            check($sformatf("fin_cycle[%0d]", h), fin_cyc[h], m_cyc[h]);
            check($sformatf("fin_instret[%0d]", h), fin_ins[h], m_ins[h]);
        end
        check("state", 64'(state), 64'(m_phase));
        check("all_done", 64'(all_done), 64'(m_phase == 2));
        check("timeout", 64'(timeout), 64'(m_phase == 3));
        check("fail", 64'(fail), 64'(m_fail()));
    endtask

    task automatic randomize_data();
        for (int h = 0; h < int'(NH); h++) begin
            cyc[h] = {32'($urandom), 32'($urandom)};
            ins[h] = 64'($urandom);
        end
    endtask

    // Called at a negedge with inputs set; returns at the next negedge
    task automatic step();
        @(posedge clk_i);
        model_clock();
        n_edge++;
        @(negedge clk_i);
        compare();
        ex = '0;
        randomize_data();
    endtask

    task automatic idle_to(input int e);
        while (n_edge < e - 1) step();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        ex = '0;
        model_reset();
        #1 compare();
        @(negedge clk_i);
        rst_ni = 1'b1;
        n_edge = 0;
        randomize_data();
        compare();
    endtask

    task automatic ecall(input int h, input logic [63:0] c, input logic [63:0] cy,
                         input logic [63:0] in, input logic [63:0] ec);
        ex[h] = 1'b1; cause[h] = c; cyc[h] = cy; ins[h] = in; code[h] = ec;
    endtask

    logic [63:0] cause_tab [7];

    initial begin
        cause_tab[0] = 64'h8; cause_tab[1] = 64'h9; cause_tab[2] = 64'hB;
        cause_tab[3] = 64'h2; cause_tab[4] = 64'h0; cause_tab[5] = 64'h3;
        cause_tab[6] = 64'h8000_0000_0000_0008;
        model_reset();
        randomize_data();

        // Two harts finish at edges 10 and 20, then drain and done
        do_reset();
        idle_to(10); ecall(0, 64'hB, 64'd1000, 64'd800, 64'd0); step();
        check("lit_done_h0", 64'(hart_done), 64'b01);
        idle_to(20); ecall(1, 64'h8, 64'd2000, 64'd1500, 64'd0); step();
        check("lit_done_all", 64'(hart_done), 64'b11);
        check("lit_state_run20", 64'(state), 64'd0);
        step();
        check("lit_state_drain21", 64'(state), 64'd1);
        idle_to(37);
        check("lit_state_drain36", 64'(state), 64'd1);
        step();
        check("lit_state_done37", 64'(state), 64'd2);
        check("lit_fin_cycle0", fin_cyc[0], 64'd1000);
        check("lit_fin_cycle1", fin_cyc[1], 64'd2000);
        check("lit_mipc0", (fin_ins[0] * 64'd1000) / fin_cyc[0], 64'd800);
        check("lit_mipc1", (fin_ins[1] * 64'd1000) / fin_cyc[1], 64'd750);
        check("lit_pass", 64'(fail), 64'd0);
        repeat (3) step();

        // Non-ecall cause ignored, later ecall captures, then watchdog fires
        do_reset();
        idle_to(2); ecall(0, 64'h2, 64'd5, 64'd5, 64'd0); step();
        check("lit_cause2_ignored", 64'(hart_done), 64'b00);
        ecall(0, 64'h9, 64'd77, 64'd66, 64'd0); step();
        check("lit_cause9_fin", fin_cyc[0], 64'd77);
        idle_to(50);
        check("lit_no_timeout49", 64'(timeout), 64'd0);
        step();
        check("lit_timeout50", 64'(timeout), 64'd1);
        check("lit_done_01", 64'(hart_done), 64'b01);
        ecall(1, 64'h8, 64'd9, 64'd9, 64'd0); step();
        check("lit_timeout_terminal", 64'(hart_done), 64'b01);
        repeat (3) step();

        // Simultaneous ecalls with a failing code, recapture blocked, reset mid-drain
        do_reset();
        idle_to(5);
        ecall(0, 64'h8, 64'd300, 64'd200, 64'd0);
        ecall(1, 64'hB, 64'd400, 64'd100, 64'd3);
        step();
        check("lit_both_done", 64'(hart_done), 64'b11);
        check("lit_fail", 64'(fail), 64'd1);
        ecall(0, 64'h9, 64'd999, 64'd999, 64'd7); step();
        check("lit_no_overwrite", fin_cyc[0], 64'd300);
        repeat (4) step();
        check("lit_mid_drain", 64'(state), 64'd1);
        do_reset();
        check("lit_reset_state", 64'(state), 64'd0);
        check("lit_reset_done", 64'(hart_done), 64'd0);
        check("lit_reset_fail", 64'(fail), 64'd0);

        // Final ecall on the watchdog expiry clock: drain wins
        do_reset();
        idle_to(3); ecall(0, 64'h8, 64'd10, 64'd10, 64'd0); step();
        idle_to(50); ecall(1, 64'h9, 64'd20, 64'd20, 64'd0); step();
        check("lit_race_no_timeout", 64'(timeout), 64'd0);
        step();
        check("lit_race_drain", 64'(state), 64'd1);
        repeat (DR + 2) step();

        // Randomized ecall traffic
        for (int t = 0; t < 30; t++) begin
            do_reset();
            for (int c = 0; c < 90; c++) begin
                if (m_phase == 1 && m_fail()) break;
                if (m_phase >= 2 && $urandom_range(0, 3) == 0) break;
                for (int h = 0; h < int'(NH); h++) begin
                    if ($urandom_range(0, 9) == 0) begin
                        ecall(h, cause_tab[$urandom_range(0, 6)], {32'($urandom), 32'($urandom)},
                              64'($urandom), ($urandom_range(0, 3) == 0) ? 64'($urandom_range(1, 255)) : 64'd0);
                    end
                end
                step();
            end
        end
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
